// File: rtl/pwm_dac_streamer.sv
// Streaming PWM DAC: samples are queued in a small FIFO and each code sets the
// PWM duty cycle for HOLD_PERIODS carrier periods of 2^WIDTH clocks.
module pwm_dac_streamer #(
    parameter int WIDTH        = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int HOLD_PERIODS = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic [WIDTH-1:0]              s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic                          clr_underrun,
    output logic                          pwm_out,
    output logic [WIDTH-1:0]              cur_code,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          sample_strobe,
    output logic                          underrun
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int HW = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;
    localparam logic [WIDTH-1:0] CARRIER_MAX = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PRIME = 2'b01,
        ST_RUN   = 2'b10
    } state_e;

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    carrier_q, carrier_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic [WIDTH-1:0]    code_q, code_d;
    logic                strobe_q, strobe_d;
    logic                pwm_q, pwm_d;
    logic                underrun_q, underrun_d;
    logic [WIDTH-1:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]       level_q, level_d;
    logic                push_s, pop_s, ur_set_s;
    logic                fifo_empty_s, boundary_s, due_s;

    assign fifo_empty_s = (level_q == {LW{1'b0}});
    assign s_ready      = (level_q != LW'(FIFO_DEPTH));
    assign push_s       = s_valid && s_ready;
    assign boundary_s   = (carrier_q == CARRIER_MAX);
    assign due_s        = boundary_s && (hold_q == HW'(HOLD_PERIODS - 1));

    // Playback sequencing: carrier, hold counter, code load and FIFO pop requests.
    always_comb begin
        state_d   = state_q;
        carrier_d = carrier_q;
        hold_d    = hold_q;
        code_d    = code_q;
        strobe_d  = 1'b0;
        pop_s     = 1'b0;
        ur_set_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                carrier_d = {WIDTH{1'b0}};
                hold_d    = {HW{1'b0}};
                if (enable) begin
                    state_d = ST_PRIME;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRIME: begin
                carrier_d = {WIDTH{1'b0}};
                hold_d    = {HW{1'b0}};
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (!fifo_empty_s) begin
                    pop_s    = 1'b1;
                    code_d   = mem_q[rd_ptr_q];
                    strobe_d = 1'b1;
                    state_d  = ST_RUN;
                end else begin
                    state_d = ST_PRIME;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    // Leaving RUN keeps the code and FIFO; only the timebase restarts.
                    state_d   = ST_IDLE;
                    carrier_d = {WIDTH{1'b0}};
                    hold_d    = {HW{1'b0}};
                end else begin
                    state_d   = ST_RUN;
                    carrier_d = carrier_q + WIDTH'(1);
                    if (due_s) begin
                        hold_d = {HW{1'b0}};
                        if (!fifo_empty_s) begin
                            pop_s    = 1'b1;
                            code_d   = mem_q[rd_ptr_q];
                            strobe_d = 1'b1;
                        end else begin
                            ur_set_s = 1'b1;
                        end
                    end else if (boundary_s) begin
                        hold_d = hold_q + HW'(1);
                    end else begin
                        hold_d = hold_q;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                carrier_d = {WIDTH{1'b0}};
                hold_d    = {HW{1'b0}};
            end
        endcase
    end

    // Output and flag next-state; pwm is computed from next-state so it is registered.
    always_comb begin
        pwm_d = (state_d == ST_RUN) && (carrier_d < code_d);
        if (ur_set_s) begin
            underrun_d = 1'b1;
        end else if (clr_underrun) begin
            underrun_d = 1'b0;
        end else begin
            underrun_d = underrun_q;
        end
    end

    // FIFO occupancy next-state; simultaneous push and pop leave it unchanged.
    always_comb begin
        if (push_s && !pop_s) begin
            level_d = level_q + LW'(1);
        end else if (!push_s && pop_s) begin
            level_d = level_q - LW'(1);
        end else begin
            level_d = level_q;
        end
    end

    // Playback state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            carrier_q  <= {WIDTH{1'b0}};
            hold_q     <= {HW{1'b0}};
            code_q     <= {WIDTH{1'b0}};
            strobe_q   <= 1'b0;
            pwm_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            carrier_q  <= carrier_d;
            hold_q     <= hold_d;
            code_q     <= code_d;
            strobe_q   <= strobe_d;
            pwm_q      <= pwm_d;
            underrun_q <= underrun_d;
        end
    end

    // FIFO storage and pointers; the pop reads registered contents, so no bypass.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            level_q  <= {LW{1'b0}};
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q] <= s_data;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_q <= wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_q <= rd_ptr_q;
            end
            level_q <= level_d;
        end
    end

    assign pwm_out       = pwm_q;
    assign cur_code      = code_q;
    assign fifo_level    = level_q;
    assign sample_strobe = strobe_q;
    assign underrun      = underrun_q;

endmodule

// File: tb/tb_pwm_dac_streamer.sv
// Self-checking bench for pwm_dac_streamer (WIDTH=8, FIFO_DEPTH=4, HOLD_PERIODS=2).
// Expected waveforms come from the duty rule: per period, code clocks high.
module tb_pwm_dac_streamer;

    localparam int W   = 8;
    localparam int D   = 4;
    localparam int H   = 2;
    localparam int P   = 256;
    localparam int WIN = H * P;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic       clr_underrun;
    logic       pwm_out;
    logic [7:0] cur_code;
    logic [2:0] fifo_level;
    logic       sample_strobe;
    logic       underrun;

    int tests = 0;
    int fails = 0;

    pwm_dac_streamer #(.WIDTH(W), .FIFO_DEPTH(D), .HOLD_PERIODS(H)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .clr_underrun(clr_underrun), .pwm_out(pwm_out), .cur_code(cur_code),
        .fifo_level(fifo_level), .sample_strobe(sample_strobe), .underrun(underrun)
    );

    always #5 clk = ~clk;

    // One full hold window of a code: duty per period, strobe only at the start.
    task automatic play_window(input logic [7:0] code, input logic exp_strobe,
                               input int exp_level, input logic exp_ur,
                               input int push_k, input logic [7:0] push_v, input string tag);
        int err_pwm = 0, err_code = 0, highs = 0, extra_strobes = 0;
        for (int k = 0; k < WIN; k++) begin
            @(negedge clk);
            if (k == 0) begin
                tests++;
                if (sample_strobe !== exp_strobe) begin
                    fails++; $display("FAIL %s strobe: got %b expected %b", tag, sample_strobe, exp_strobe);
                end
                tests++;
                if (fifo_level !== 3'(exp_level)) begin
                    fails++; $display("FAIL %s level: got %0d expected %0d", tag, fifo_level, exp_level);
                end
                tests++;
                if (underrun !== exp_ur) begin
                    fails++; $display("FAIL %s underrun: got %b expected %b", tag, underrun, exp_ur);
                end
            end
            if (pwm_out !== ((k % P) < int'(code))) err_pwm++;
            if (pwm_out === 1'b1) highs++;
            if (cur_code !== code) err_code++;
            if (k > 0 && sample_strobe !== 1'b0) extra_strobes++;
            if (k == push_k) begin
                s_valid = 1'b1;
                s_data  = push_v;
            end else begin
                s_valid = 1'b0;
            end
        end
        tests++;
        if (err_pwm !== 0) begin
            fails++; $display("FAIL %s pwm cycles wrong: got %0d expected 0", tag, err_pwm);
        end
        tests++;
        if (highs !== H * int'(code)) begin
            fails++; $display("FAIL %s high clocks: got %0d expected %0d", tag, highs, H * int'(code));
        end
        tests++;
        if (err_code !== 0) begin
            fails++; $display("FAIL %s cur_code %02h cycles: got %0d expected 0", tag, code, err_code);
        end
        tests++;
        if (extra_strobes !== 0) begin
            fails++; $display("FAIL %s extra strobes: got %0d expected 0", tag, extra_strobes);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b0; s_valid = 1'b0; s_data = 8'h00; clr_underrun = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (pwm_out !== 1'b0) begin fails++; $display("FAIL reset pwm: got %b expected 0", pwm_out); end
        tests++; if (cur_code !== 8'h00) begin fails++; $display("FAIL reset code: got %02h expected 00", cur_code); end
        tests++; if (fifo_level !== 3'd0) begin fails++; $display("FAIL reset level: got %0d expected 0", fifo_level); end
        tests++; if (s_ready !== 1'b1) begin fails++; $display("FAIL reset ready: got %b expected 1", s_ready); end
        tests++; if (sample_strobe !== 1'b0) begin fails++; $display("FAIL reset strobe: got %b expected 0", sample_strobe); end
        tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL reset underrun: got %b expected 0", underrun); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_prefill();
        logic [7:0] codes [4];
        codes[0] = 8'h40; codes[1] = 8'h80; codes[2] = 8'hC0; codes[3] = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1; s_data = codes[i];
            @(negedge clk);
            tests++;
            if (fifo_level !== 3'(i + 1)) begin
                fails++; $display("FAIL prefill level: got %0d expected %0d", fifo_level, i + 1);
            end
        end
        s_data = 8'h11;
        repeat (2) @(negedge clk);
        s_valid = 1'b0;
        tests++; if (fifo_level !== 3'd4) begin fails++; $display("FAIL full level: got %0d expected 4", fifo_level); end
        tests++; if (s_ready !== 1'b0) begin fails++; $display("FAIL full ready: got %b expected 0", s_ready); end
        tests++; if (pwm_out !== 1'b0) begin fails++; $display("FAIL idle pwm: got %b expected 0", pwm_out); end
    endtask

    task automatic test_playback();
        enable = 1'b1;
        @(negedge clk);
        tests++; if (pwm_out !== 1'b0) begin fails++; $display("FAIL prime pwm: got %b expected 0", pwm_out); end
        tests++; if (sample_strobe !== 1'b0) begin fails++; $display("FAIL prime strobe: got %b expected 0", sample_strobe); end
        play_window(8'h40, 1'b1, 3, 1'b0, -1, 8'h00, "play40");
        play_window(8'h80, 1'b1, 2, 1'b0, -1, 8'h00, "play80");
        play_window(8'hC0, 1'b1, 1, 1'b0, -1, 8'h00, "playC0");
        play_window(8'hFF, 1'b1, 0, 1'b0, -1, 8'h00, "playFF");
    endtask

    task automatic test_underrun();
        int err_pwm = 0, err_code = 0, err_strobe = 0, err_ur = 0;
        for (int k = 0; k < WIN; k++) begin
            @(negedge clk);
            if (pwm_out !== ((k % P) < 255)) err_pwm++;
            if (cur_code !== 8'hFF) err_code++;
            if (sample_strobe !== 1'b0) err_strobe++;
            if (underrun !== ((k <= 10) ? 1'b1 : 1'b0)) err_ur++;
            clr_underrun = (k == 10 || k == WIN - 1) ? 1'b1 : 1'b0;
        end
        @(negedge clk);
        clr_underrun = 1'b0;
        tests++; if (err_pwm !== 0) begin fails++; $display("FAIL underrun pwm cycles: got %0d expected 0", err_pwm); end
        tests++; if (err_code !== 0) begin fails++; $display("FAIL underrun code cycles: got %0d expected 0", err_code); end
        tests++; if (err_strobe !== 0) begin fails++; $display("FAIL underrun strobe cycles: got %0d expected 0", err_strobe); end
        tests++; if (err_ur !== 0) begin fails++; $display("FAIL underrun flag cycles: got %0d expected 0", err_ur); end
        tests++; if (underrun !== 1'b1) begin fails++; $display("FAIL set-beats-clear: got %b expected 1", underrun); end
        tests++; if (sample_strobe !== 1'b0) begin fails++; $display("FAIL underrun strobe: got %b expected 0", sample_strobe); end
        tests++; if (cur_code !== 8'hFF) begin fails++; $display("FAIL underrun code: got %02h expected FF", cur_code); end
    endtask

    task automatic test_disable();
        int err_pwm = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (pwm_out !== ((k % P) < 255)) err_pwm++;
            s_valid = (k <= 2) ? 1'b1 : 1'b0;
            s_data  = (k == 1) ? 8'h00 : 8'hFF;
        end
        enable = 1'b0;
        @(negedge clk);
        tests++; if (err_pwm !== 0) begin fails++; $display("FAIL pre-disable pwm cycles: got %0d expected 0", err_pwm); end
        tests++; if (pwm_out !== 1'b0) begin fails++; $display("FAIL disable pwm: got %b expected 0", pwm_out); end
        tests++; if (cur_code !== 8'hFF) begin fails++; $display("FAIL disable code: got %02h expected FF", cur_code); end
        tests++; if (fifo_level !== 3'd2) begin fails++; $display("FAIL disable level: got %0d expected 2", fifo_level); end
        err_pwm = 0;
        repeat (4) begin
            @(negedge clk);
            if (pwm_out !== 1'b0) err_pwm++;
        end
        tests++; if (err_pwm !== 0) begin fails++; $display("FAIL idle pwm cycles: got %0d expected 0", err_pwm); end
        clr_underrun = 1'b1;
        @(negedge clk);
        clr_underrun = 1'b0;
        tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL clear underrun: got %b expected 0", underrun); end
        enable = 1'b1;
        @(negedge clk);
        tests++; if (pwm_out !== 1'b0) begin fails++; $display("FAIL reprime pwm: got %b expected 0", pwm_out); end
        tests++; if (cur_code !== 8'hFF) begin fails++; $display("FAIL reprime code: got %02h expected FF", cur_code); end
    endtask

    task automatic test_extremes();
        play_window(8'h00, 1'b1, 1, 1'b0, -1, 8'h00, "code00");
        play_window(8'hFF, 1'b1, 0, 1'b0, -1, 8'h00, "codeFF");
        @(negedge clk);
        tests++; if (underrun !== 1'b1) begin fails++; $display("FAIL extremes underrun: got %b expected 1", underrun); end
        enable = 1'b0;
        @(negedge clk);
        clr_underrun = 1'b1;
        @(negedge clk);
        clr_underrun = 1'b0;
    endtask

    // Random codes via a queue model; includes push+pop on one edge and a push into an empty FIFO at a due edge.
    task automatic test_random();
        logic [7:0] q [$];
        logic [7:0] cur, pv;
        logic       strobe_exp, ur_exp, last;
        bit         extra_done, nb_done;
        int         n, pk, pre;
        n = $urandom_range(2, 4);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            pv = 8'($urandom_range(0, 255));
            s_valid = 1'b1; s_data = pv; q.push_back(pv);
            @(negedge clk);
            s_valid = 1'b0;
        end
        tests++; if (fifo_level !== 3'(n)) begin fails++; $display("FAIL rand level: got %0d expected %0d", fifo_level, n); end
        tests++; if (s_ready !== (n < D)) begin fails++; $display("FAIL rand ready: got %b expected %b", s_ready, n < D); end
        enable = 1'b1;
        @(negedge clk);
        tests++; if (pwm_out !== 1'b0) begin fails++; $display("FAIL rand prime pwm: got %b expected 0", pwm_out); end
        cur = q.pop_front(); strobe_exp = 1'b1; ur_exp = 1'b0;
        extra_done = 0; nb_done = 0;
        for (int w = 0; w < 10; w++) begin
            last = (q.size() == 0 && nb_done);
            pk = -1; pv = 8'($urandom_range(0, 255));
            if (!extra_done) begin
                pk = WIN - 1; extra_done = 1;
            end else if (q.size() == 0 && !nb_done) begin
                pk = WIN - 1; nb_done = 1;
            end
            play_window(cur, strobe_exp, q.size(), ur_exp, pk, pv, "rand");
            if (last) break;
            pre = q.size();
            if (pre > 0) begin
                cur = q.pop_front(); strobe_exp = 1'b1;
            end else begin
                strobe_exp = 1'b0; ur_exp = 1'b1;
            end
            if (pk >= 0) q.push_back(pv);
        end
        @(negedge clk);
        s_valid = 1'b0;
        tests++; if (underrun !== 1'b1) begin fails++; $display("FAIL rand final underrun: got %b expected 1", underrun); end
    endtask

    task automatic test_reset_midrun();
        enable = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_data  = (i == 0) ? 8'hC0 : 8'($urandom_range(0, 255));
            @(negedge clk);
        end
        s_valid = 1'b0;
        enable  = 1'b1;
        @(negedge clk);
        repeat (5) @(negedge clk);
        tests++; if (fifo_level !== 3'd3) begin fails++; $display("FAIL midrun level: got %0d expected 3", fifo_level); end
        tests++; if (pwm_out !== 1'b1) begin fails++; $display("FAIL midrun pwm: got %b expected 1", pwm_out); end
        #2 reset_n = 1'b0;
        #1;
        tests++; if (pwm_out !== 1'b0) begin fails++; $display("FAIL async reset pwm: got %b expected 0", pwm_out); end
        tests++; if (cur_code !== 8'h00) begin fails++; $display("FAIL async reset code: got %02h expected 00", cur_code); end
        tests++; if (fifo_level !== 3'd0) begin fails++; $display("FAIL async reset level: got %0d expected 0", fifo_level); end
        tests++; if (s_ready !== 1'b1) begin fails++; $display("FAIL async reset ready: got %b expected 1", s_ready); end
        tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL async reset underrun: got %b expected 0", underrun); end
        tests++; if (sample_strobe !== 1'b0) begin fails++; $display("FAIL async reset strobe: got %b expected 0", sample_strobe); end
        enable = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_prefill();
        test_playback();
        test_underrun();
        test_disable();
        test_extremes();
        test_random();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pwm_dac_streamer.md
Name: pwm_dac_streamer

Overview:
Streaming PWM DAC output block. It is the digital-to-analog direction of the same PWM/RC-filter path used by the discrete ADC. Samples arrive over a valid/ready stream and are buffered in a small FIFO. Each sample drives the PWM duty cycle for a fixed number of carrier periods, so the RC filter reproduces a waveform at a steady sample rate.

Parameters:
WIDTH, 8, code width; PWM carrier period is 2^WIDTH clocks
FIFO_DEPTH, 4, sample FIFO entries; power of 2, >=2
HOLD_PERIODS, 4, carrier periods each sample is held; >=1

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
enable  input  1  1 = play samples, 0 = idle
s_data  input  WIDTH  sample code
s_valid  input  1  s_data valid
s_ready  output  1  FIFO can accept a sample
clr_underrun  input  1  clears the underrun flag
pwm_out  output  1  PWM drive to RC filter
cur_code  output  WIDTH  duty code currently in effect
fifo_level  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy, 0..FIFO_DEPTH
sample_strobe  output  1  1-cycle pulse when a new code takes effect
underrun  output  1  sticky; set when a sample is due and the FIFO is empty

Behaviour:
- Reset: reset_n low clears state, all outputs, carrier, hold counter and FIFO pointers asynchronously. After reset: pwm_out=0, cur_code=0, fifo_level=0, s_ready=1, sample_strobe=0, underrun=0.
- Push: a sample is accepted when s_valid && s_ready. s_ready = (fifo_level != FIFO_DEPTH), independent of enable, so the FIFO can be prefilled while idle.
- Push and pop in the same cycle: level is unchanged.
- No bypass: a push into an empty FIFO is not visible to a pop in the same cycle.
- Carrier: WIDTH-bit counter. It runs only in RUN and wraps from 2^WIDTH-1 to 0. A "boundary" is the cycle in which carrier == 2^WIDTH-1.
- pwm_out = (state==RUN) && (carrier < cur_code).
  - Code 0: pwm_out never high.
  - Code 2^WIDTH-1: high for 2^WIDTH-1 clocks, low for 1 clock per period.
- States:
  - IDLE:
    - carrier=0, hold=0, pwm_out=0.
    - enable=1 -> PRIME.
  - PRIME:
    - carrier held at 0, pwm_out=0.
    - If the FIFO is non-empty: pop, cur_code <= head, hold <= 0, -> RUN.
    - enable=0 -> IDLE; this takes priority over the pop.
  - RUN:
    - Carrier increments every cycle.
    - At each boundary: if hold == HOLD_PERIODS-1, a new sample is due and hold <= 0; otherwise hold increments.
    - Sample due, FIFO non-empty: pop and load cur_code; the new code is in effect from the next cycle (carrier == 0).
    - Sample due, FIFO empty: cur_code holds its previous value and underrun <= 1.
    - enable=0 -> IDLE next cycle, regardless of carrier position.
- Latency:
  - First code takes effect 1 cycle after entering PRIME with a non-empty FIFO.
  - Each sample occupies exactly HOLD_PERIODS * 2^WIDTH clocks of pwm_out.
- sample_strobe: registered pulse, high in the first cycle a newly popped code is in effect. It is not asserted on an underrun.
- underrun: clr_underrun clears it. If set and clear occur in the same cycle, set wins.
- Leaving RUN (enable=0): cur_code and FIFO contents are retained. Re-enabling passes through PRIME and pops the next sample.
- fifo_level is updated on the clock edge after each push or pop.

Test Plan:
- Reset: drive reset_n low mid-RUN with 3 samples queued -> immediately pwm_out=0, cur_code=0, fifo_level=0, s_ready=1, underrun=0.
- Prefill (WIDTH=8, DEPTH=4, HOLD=2): enable=0, push 0x40, 0x80, 0xC0, 0xFF, then offer a 5th sample 0x11 -> fifo_level=4, s_ready=0, 0x11 not accepted, pwm_out stays 0.
- Playback: enable=1 with the FIFO prefilled as above -> the following sequence:
  - PRIME for 1 cycle, then cur_code=0x40 with sample_strobe=1.
  - pwm_out high for 64 of every 256 clocks for 512 clocks.
  - Then 0x80, giving 128 high clocks per period.
  - sample_strobe pulses every 512 clocks.
- Underrun: after 0xFF has played for 512 clocks with the FIFO empty -> underrun=1 at the boundary, cur_code stays 0xFF, no strobe. Assert clr_underrun in the same cycle as the next underrun -> underrun remains 1.
- Extremes: code 0x00 -> pwm_out is 0 for the whole hold. Code 0xFF -> 255 high clocks and 1 low clock per period.
- Disable: drop enable at carrier=100 -> next cycle IDLE with pwm_out=0 and cur_code retained. Re-enable -> PRIME pops the next queued sample, and the carrier restarts at 0.
